// File: rtl/program_counter_unit.sv
// rtl/program_counter_unit.sv - fetch-stage program counter with return-address stack
// Supports SEQ, BRANCH, JUMP, CALL, RET and VECTOR ops, with a sticky stack error flag.
module program_counter_unit #(
   parameter int unsigned     N            = 16,
   parameter int unsigned     STEP         = 1,
   parameter logic [N-1:0]    RESET_VECTOR = '0,
   parameter int unsigned     DEPTH        = 4,
   localparam int unsigned    CW           = $clog2(DEPTH + 1)
) (
   input  logic          Clock,
   input  logic          Reset_n,
   input  logic          PC_write_data,
   input  logic [2:0]    PC_op,
   input  logic [N-1:0]  PC_target,
   input  logic [N-1:0]  PC_offset,
   output logic [N-1:0]  PC_out,
   output logic [N-1:0]  PC_seq,
   output logic [CW-1:0] Stack_count,
   output logic          Stack_full,
   output logic          Stack_empty,
   output logic          Stack_error
);

   localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [N-1:0]  STEP_N = N'(STEP);
   localparam logic [CW-1:0] ONE    = CW'(1);
   localparam logic [CW-1:0] FULL   = CW'(DEPTH);

   localparam logic [2:0] OP_SEQ    = 3'b000;
   localparam logic [2:0] OP_BRANCH = 3'b001;
   localparam logic [2:0] OP_JUMP   = 3'b010;
   localparam logic [2:0] OP_CALL   = 3'b011;
   localparam logic [2:0] OP_RET    = 3'b100;
   localparam logic [2:0] OP_VECTOR = 3'b101;

   logic [N-1:0]  r_pc;
   logic [CW-1:0] r_count;
   logic          r_error;
   logic [N-1:0]  r_stack [2**AW];

   logic [N-1:0]  w_pc_nxt;
   logic [CW-1:0] w_count_nxt;
   logic          w_error_nxt;
   logic          w_push;
   logic          w_full;
   logic          w_empty;
   logic [AW-1:0] w_push_idx;
   logic [AW-1:0] w_top_idx;
   logic [N-1:0]  w_seq;

   assign w_seq      = r_pc + STEP_N;
   assign w_full     = (r_count == FULL);
   assign w_empty    = (r_count == '0);
   assign w_push_idx = r_count[AW-1:0];
   assign w_top_idx  = AW'(r_count - ONE);

   always_comb begin
      w_pc_nxt    = r_pc;
      w_count_nxt = r_count;
      w_error_nxt = r_error;
      w_push      = 1'b0;
      if (PC_write_data) begin
         case (PC_op)
            OP_SEQ:    w_pc_nxt = w_seq;
            OP_BRANCH: w_pc_nxt = r_pc + PC_offset;
            OP_JUMP:   w_pc_nxt = PC_target;
            OP_CALL: begin
               w_pc_nxt = PC_target;
               if (w_full) begin
                  w_error_nxt = 1'b1;
               end else begin
                  w_push      = 1'b1;
                  w_count_nxt = r_count + ONE;
               end
            end
            OP_RET: begin
               if (w_empty) begin
                  // Underflow falls through to the next sequential instruction
                  w_pc_nxt    = w_seq;
                  w_error_nxt = 1'b1;
               end else begin
                  w_pc_nxt    = r_stack[w_top_idx];
                  w_count_nxt = r_count - ONE;
               end
            end
            OP_VECTOR: begin
               w_pc_nxt    = RESET_VECTOR;
               w_count_nxt = '0;
               w_error_nxt = 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         r_pc    <= RESET_VECTOR;
         r_count <= '0;
         r_error <= 1'b0;
      end else begin
         r_pc    <= w_pc_nxt;
         r_count <= w_count_nxt;
         r_error <= w_error_nxt;
      end
   end

   // Stack storage needs no reset; pushes are suppressed while reset is held
   always_ff @(posedge Clock) begin
      if (w_push && Reset_n) begin
         r_stack[w_push_idx] <= w_seq;
      end
   end

   assign PC_out      = r_pc;
   assign PC_seq      = w_seq;
   assign Stack_count = r_count;
   assign Stack_full  = w_full;
   assign Stack_empty = w_empty;
   assign Stack_error = r_error;

endmodule
